// File: rtl/simplerisc_pkg.sv
// Shared constants and types for the SimpleRisc register-writeback slice.
// Configuration macro: WB_BYPASS_EN (see wb_unit.sv).
package simplerisc_pkg;

  localparam int NUM_REGS = 16;
  localparam int RA_IDX   = 15;
  localparam int XLEN     = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  // Destination-register field inside the instruction word.
  localparam int RD_HI = 25;
  localparam int RD_LO = 22;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LD_WAIT = 1'b1
  } wb_state_t;

  // One register-file write request.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_req_t;

  // Return address stored by call; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] ret_addr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/reg_file_16x32.sv
// 16x32 architectural register file: one synchronous write port, two
// asynchronous read ports, synchronous clear. No register is hard-wired.
module reg_file_16x32
  import simplerisc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_a,
  output logic [XLEN-1:0]   rdata_b
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Storage update: clear everything on reset, otherwise commit the write.
  // NOTE: the storage is reset on purpose because the architecture defines
  // every register as zero after reset; this keeps it in flops, not a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      // NOTE: non-blocking assignment so every reader of regs in this edge
      // sees the pre-edge value, exactly like real flops.
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/wb_unit.sv
// Register-writeback stage of the single-cycle SimpleRisc core.
// Owns the register file, selects the write source (call / load / ALU),
// stalls the core while load data is outstanding and counts retirements.
// Configuration macro: WB_BYPASS_EN -- when defined, a write committed at the
// coming edge is forwarded to both read ports in the same cycle.
module wb_unit
  import simplerisc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [XLEN-1:0]   inst,
  input  logic [XLEN-1:0]   PC,
  input  logic [XLEN-1:0]   aluResult,
  input  logic              isWb,
  input  logic              isLd,
  input  logic              isCall,
  input  logic              ld_valid,
  input  logic [XLEN-1:0]   ld_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [XLEN-1:0]   rd_data_a,
  output logic [XLEN-1:0]   rd_data_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]   wr_data,
  output logic [XLEN-1:0]   retired
);

  wb_state_t         state, state_nxt;
  logic [ADDR_W-1:0] pend_rd;
  logic              latch_rd;
  logic              retire;
  wr_req_t           wr;
  logic [ADDR_W-1:0] inst_rd;
  logic [XLEN-1:0]   store_a, store_b;

  // Only the rd field of the instruction matters at writeback.
  assign inst_rd = inst[RD_HI:RD_LO];
  logic unused_inst;
  assign unused_inst = ^{inst[XLEN-1:RD_HI+1], inst[RD_LO-1:0]};

  assign wb_ready = (state == IDLE);

  // Next-state, write-source selection and retire decision.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_nxt = state;
    latch_rd  = 1'b0;
    retire    = 1'b0;
    wr        = '0;
    unique case (state)
      IDLE: begin
        if (wb_valid) begin
          if (isCall) begin
            wr     = '{en: 1'b1, addr: ADDR_W'(RA_IDX), data: ret_addr(PC)};
            retire = 1'b1;
          end else if (isLd) begin
            latch_rd  = 1'b1;
            state_nxt = LD_WAIT;
          end else if (isWb) begin
            wr     = '{en: 1'b1, addr: inst_rd, data: aluResult};
            retire = 1'b1;
          end else begin
            retire = 1'b1;
          end
        end
      end
      LD_WAIT: begin
        if (ld_valid) begin
          wr        = '{en: 1'b1, addr: pend_rd, data: ld_data};
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing is committed while reset is asserted, including a late load.
    if (reset) begin
      wr = '0;
    end
  end

  assign wr_en   = wr.en;
  assign wr_addr = wr.addr;
  assign wr_data = wr.data;

  // FSM state, pending load destination and retirement counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pend_rd <= '0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (latch_rd) begin
        pend_rd <= inst_rd;
      end
      if (retire) begin
        retired <= retired + XLEN'(1);
      end
    end
  end

  reg_file_16x32 u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (wr.en),
    .waddr   (wr.addr),
    .wdata   (wr.data),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (store_a),
    .rdata_b (store_b)
  );

  // Read ports: stored contents, optionally forwarded from the pending write.
`ifdef WB_BYPASS_EN
  always_comb begin
    rd_data_a = (wr.en && (rd_addr_a == wr.addr)) ? wr.data : store_a;
    rd_data_b = (wr.en && (rd_addr_b == wr.addr)) ? wr.data : store_b;
  end
`else
  always_comb begin
    rd_data_a = store_a;
    rd_data_b = store_b;
  end
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: stimulus pushes the expected register writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] inst;
  logic [31:0] PC;
  logic [31:0] aluResult;
  logic        isWb, isLd, isCall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] retired;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_wr_t;

  exp_wr_t exp_q[$];
  int checks = 0;
  int errors = 0;

  wb_unit dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .inst      (inst),
    .PC        (PC),
    .aluResult (aluResult),
    .isWb      (isWb),
    .isLd      (isLd),
    .isCall    (isCall),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%08h expected no write", wr_addr, wr_data);
      end else begin
        exp_wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
        check("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; isWb = 0; isLd = 0; isCall = 0; ld_valid = 0;
    inst = '0; PC = '0; aluResult = '0; ld_data = '0;
  endtask

  function automatic logic [31:0] rd_inst(input logic [3:0] rd);
    return {6'd0, rd, 22'd0};
  endfunction

  initial begin
    reset = 1; rd_addr_a = 0; rd_addr_b = 0;
    idle_inputs();
    tick();
    // A write attempted while reset is high must be suppressed.
    wb_valid = 1; isWb = 1; inst = rd_inst(4'd1); aluResult = 32'h99;
    @(negedge clk);
    check("wr_en_in_reset", {31'd0, wr_en}, 32'd0);
    tick();
    reset = 0;
    idle_inputs();

    // Reset state.
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      #1;
      check("reset_rd_a", rd_data_a, 32'd0);
      check("reset_rd_b", rd_data_b, 32'd0);
    end
    check("reset_retired", retired, 32'd0);
    check("reset_wr_en", {31'd0, wr_en}, 32'd0);
    check("reset_ready", {31'd0, wb_ready}, 32'd1);
    tick();

    // ALU write to r3.
    wb_valid = 1; isWb = 1; inst = rd_inst(4'd3); aluResult = 32'hDEADBEEF; rd_addr_a = 3;
    exp_q.push_back('{4'd3, 32'hDEADBEEF});
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("alu_same_cycle", rd_data_a, 32'hDEADBEEF);
`else
    check("alu_same_cycle", rd_data_a, 32'd0);
`endif
    tick();
    idle_inputs();
    @(negedge clk);
    check("alu_r3", rd_data_a, 32'hDEADBEEF);
    check("alu_retired", retired, 32'd1);
    tick();

    // Calls: normal and wrapping return address.
    wb_valid = 1; isCall = 1; PC = 32'h100; rd_addr_b = 15;
    exp_q.push_back('{4'd15, 32'h104});
    tick();
    idle_inputs();
    @(negedge clk);
    check("call_r15", rd_data_b, 32'h104);
    check("call_retired", retired, 32'd2);
    tick();
    wb_valid = 1; isCall = 1; PC = 32'hFFFFFFFC;
    exp_q.push_back('{4'd15, 32'h0});
    tick();
    idle_inputs();
    @(negedge clk);
    check("call_wrap_r15", rd_data_b, 32'h0);
    check("call_wrap_retired", retired, 32'd3);
    tick();

    // Instruction without write flags retires silently.
    wb_valid = 1;
    tick();
    idle_inputs();
    @(negedge clk);
    check("nop_retired", retired, 32'd4);
    tick();

    // Load to r7 with three idle wait cycles; held wb_valid is ignored.
    wb_valid = 1; isLd = 1; inst = rd_inst(4'd7); rd_addr_a = 7;
    @(negedge clk);
    check("ld_issue_ready", {31'd0, wb_ready}, 32'd1);
    tick();
    isLd = 0; isWb = 1; inst = rd_inst(4'd5); aluResult = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld_wait_ready", {31'd0, wb_ready}, 32'd0);
      check("ld_wait_retired", retired, 32'd4);
      tick();
    end
    ld_valid = 1; ld_data = 32'h12345678;
    exp_q.push_back('{4'd7, 32'h12345678});
    @(negedge clk);
    check("ld_done_ready", {31'd0, wb_ready}, 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("ld_r7", rd_data_a, 32'h12345678);
    check("ld_retired", retired, 32'd5);
    check("ld_after_ready", {31'd0, wb_ready}, 32'd1);
    tick();

    // Reset in the middle of a pending load drops it.
    wb_valid = 1; isLd = 1; inst = rd_inst(4'd7);
    tick();
    idle_inputs();
    tick();
    reset = 1;
    tick();
    reset = 0;
    ld_valid = 1; ld_data = 32'hAAAA;
    @(negedge clk);
    check("rst_ld_ready", {31'd0, wb_ready}, 32'd1);
    tick();
    idle_inputs();
    @(negedge clk);
    check("rst_ld_r7", rd_data_a, 32'd0);
    check("rst_ld_retired", retired, 32'd0);
    check("rst_ld_idle", {31'd0, wb_ready}, 32'd1);
    tick();

    // Priority: call beats load and ALU write.
    wb_valid = 1; isWb = 1; inst = rd_inst(4'd2); aluResult = 32'h55;
    exp_q.push_back('{4'd2, 32'h55});
    tick();
    isCall = 1; isLd = 1; isWb = 1; PC = 32'h20; aluResult = 32'h77;
    rd_addr_a = 2; rd_addr_b = 15;
    exp_q.push_back('{4'd15, 32'h24});
    tick();
    idle_inputs();
    @(negedge clk);
    check("prio_r15", rd_data_b, 32'h24);
    check("prio_r2", rd_data_a, 32'h55);
    check("prio_ready", {31'd0, wb_ready}, 32'd1);
    check("prio_retired", retired, 32'd2);
    tick();

    check("missing_writes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
